// File: rtl/fetch_ctrl.sv
// Fetch-stage control: loads the boot vector after reset, arbitrates PC redirects
// and stalls, and sequences interrupt entry through the vector table.
module fetch_ctrl #(
    parameter logic [7:0] RESET_VEC_ADDR = 8'h00,
    parameter logic [7:0] IRQ_VEC_ADDR   = 8'h01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hazard_stall,
    input  logic       br_taken_ex,
    input  logic [7:0] br_target_ex,
    input  logic       rti_ex,
    input  logic       irq,
    input  logic [7:0] pc_cur,
    input  logic [7:0] imem_rdata,
    output logic       vec_sel,
    output logic [7:0] vec_addr,
    output logic       pc_stall,
    output logic       pc_branch_taken,
    output logic [7:0] pc_branch_target,
    output logic       flush_if,
    output logic       flush_id,
    output logic       irq_ack,
    output logic [7:0] epc,
    output logic       int_en,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        BOOT_RD = 3'd0,
        BOOT_LD = 3'd1,
        RUN     = 3'd2,
        INT_RD  = 3'd3,
        INT_LD  = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] vec_reg_q, vec_reg_d;
    logic [7:0] epc_q, epc_d;
    logic       int_en_q, int_en_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= BOOT_RD;
            vec_reg_q <= 8'h00;
            epc_q     <= 8'h00;
            int_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_reg_q <= vec_reg_d;
            epc_q     <= epc_d;
            int_en_q  <= int_en_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        vec_reg_d        = vec_reg_q;
        epc_d            = epc_q;
        int_en_d         = int_en_q;
        vec_sel          = 1'b0;
        vec_addr         = 8'h00;
        pc_stall         = 1'b0;
        pc_branch_taken  = 1'b0;
        pc_branch_target = 8'h00;
        flush_if         = 1'b0;
        flush_id         = 1'b0;
        irq_ack          = 1'b0;

        // While reset is held the outputs already look like the boot vector read.
        if (reset) begin
            vec_sel  = 1'b1;
            vec_addr = RESET_VEC_ADDR;
            pc_stall = 1'b1;
            flush_if = 1'b1;
            flush_id = 1'b1;
        end else begin
            case (state_q)
                BOOT_RD: begin
                    vec_sel   = 1'b1;
                    vec_addr  = RESET_VEC_ADDR;
                    pc_stall  = 1'b1;
                    flush_if  = 1'b1;
                    flush_id  = 1'b1;
                    vec_reg_d = imem_rdata;
                    state_d   = BOOT_LD;
                end
                BOOT_LD: begin
                    pc_branch_taken  = 1'b1;
                    pc_branch_target = vec_reg_q;
                    flush_if         = 1'b1;
                    flush_id         = 1'b1;
                    int_en_d         = 1'b1;
                    state_d          = RUN;
                end
                RUN: begin
                    if (rti_ex) begin
                        pc_branch_taken  = 1'b1;
                        pc_branch_target = epc_q;
                        flush_if         = 1'b1;
                        flush_id         = 1'b1;
                        int_en_d         = 1'b1;
                    end else if (br_taken_ex) begin
                        pc_branch_taken  = 1'b1;
                        pc_branch_target = br_target_ex;
                        flush_if         = 1'b1;
                        flush_id         = 1'b1;
                    end else if (irq && int_en_q && !hazard_stall) begin
                        epc_d    = pc_cur;
                        int_en_d = 1'b0;
                        pc_stall = 1'b1;
                        flush_if = 1'b1;
                        state_d  = INT_RD;
                    end else begin
                        pc_stall = hazard_stall;
                        flush_id = hazard_stall;
                    end
                end
                INT_RD: begin
                    vec_sel   = 1'b1;
                    vec_addr  = IRQ_VEC_ADDR;
                    pc_stall  = 1'b1;
                    flush_if  = 1'b1;
                    vec_reg_d = imem_rdata;
                    state_d   = INT_LD;
                    // A branch resolving under entry becomes the return address instead.
                    if (br_taken_ex) begin
                        epc_d    = br_target_ex;
                        flush_id = 1'b1;
                    end
                end
                INT_LD: begin
                    pc_branch_taken  = 1'b1;
                    pc_branch_target = vec_reg_q;
                    flush_if         = 1'b1;
                    irq_ack          = 1'b1;
                    state_d          = RUN;
                    if (br_taken_ex) begin
                        epc_d    = br_target_ex;
                        flush_id = 1'b1;
                    end
                end
                default: begin
                    state_d = BOOT_RD;
                end
            endcase
        end
    end

    assign epc       = epc_q;
    assign int_en    = int_en_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: per-cycle expected outputs from a phase-counting reference
// model are queued by the driver and compared by an independent negedge monitor.
module tb_fetch_ctrl;
  localparam logic [7:0] RV = 8'h00;
  localparam logic [7:0] IV = 8'h01;
  localparam int W = 31;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, hazard_stall, br_taken_ex, rti_ex, irq;
  logic [7:0] br_target_ex, pc_cur, imem_rdata;
  logic       vec_sel, pc_stall, pc_branch_taken, flush_if, flush_id, irq_ack, int_en;
  logic [7:0] vec_addr, pc_branch_target, epc;
  logic [2:0] dbg_state;

  logic [7:0] imem [256];
  assign imem_rdata = imem[vec_sel ? vec_addr : pc_cur];

  fetch_ctrl #(.RESET_VEC_ADDR(RV), .IRQ_VEC_ADDR(IV)) dut (
    .clk(clk), .reset(reset), .hazard_stall(hazard_stall), .br_taken_ex(br_taken_ex),
    .br_target_ex(br_target_ex), .rti_ex(rti_ex), .irq(irq), .pc_cur(pc_cur),
    .imem_rdata(imem_rdata), .vec_sel(vec_sel), .vec_addr(vec_addr), .pc_stall(pc_stall),
    .pc_branch_taken(pc_branch_taken), .pc_branch_target(pc_branch_target),
    .flush_if(flush_if), .flush_id(flush_id), .irq_ack(irq_ack), .epc(epc),
    .int_en(int_en), .dbg_state(dbg_state)
  );

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: counts remaining boot / interrupt-entry steps, holds the
  // architectural registers, and treats "no steps pending" as normal execution.
  bit         m_valid = 0;
  int         m_boot, m_entry;
  logic [7:0] m_vec, m_epc;
  logic       m_int_en;

  task automatic cycle(input bit rst, input bit hz, input bit br, input logic [7:0] bt,
                       input bit rti, input bit irq_in, input logic [7:0] pc);
    logic vs, st, tk, fi, fd, ack;
    logic [7:0] va, tg;
    int n_boot, n_entry;
    logic [7:0] n_vec, n_epc;
    logic n_int_en;
    reset = rst; hazard_stall = hz; br_taken_ex = br; br_target_ex = bt;
    rti_ex = rti; irq = irq_in; pc_cur = pc;
    vs = 0; st = 0; tk = 0; fi = 0; fd = 0; ack = 0; va = 8'h00; tg = 8'h00;
    n_boot = m_boot; n_entry = m_entry; n_vec = m_vec; n_epc = m_epc; n_int_en = m_int_en;
    if (rst) begin
      vs = 1; va = RV; st = 1; fi = 1; fd = 1;
      n_boot = 2; n_entry = 0; n_vec = 8'h00; n_epc = 8'h00; n_int_en = 0;
    end else if (m_boot == 2) begin
      vs = 1; va = RV; st = 1; fi = 1; fd = 1;
      n_vec = imem[RV]; n_boot = 1;
    end else if (m_boot == 1) begin
      tk = 1; tg = m_vec; fi = 1; fd = 1; n_int_en = 1; n_boot = 0;
    end else if (m_entry == 2) begin
      vs = 1; va = IV; st = 1; fi = 1; n_vec = imem[IV]; n_entry = 1;
      if (br) begin n_epc = bt; fd = 1; end
    end else if (m_entry == 1) begin
      tk = 1; tg = m_vec; fi = 1; ack = 1; n_entry = 0;
      if (br) begin n_epc = bt; fd = 1; end
    end else if (rti) begin
      tk = 1; tg = m_epc; fi = 1; fd = 1; n_int_en = 1;
    end else if (br) begin
      tk = 1; tg = bt; fi = 1; fd = 1;
    end else if (irq_in && m_int_en && !hz) begin
      n_epc = pc; n_int_en = 0; st = 1; fi = 1; n_entry = 2;
    end else begin
      st = hz; fd = hz;
    end
    if (m_valid)
      exp_q.push_back({vs, va, st, tk, tg, fi, fd, ack, m_epc, m_int_en});
    @(posedge clk);
    if (rst || m_valid) begin
      m_valid = 1; m_boot = n_boot; m_entry = n_entry;
      m_vec = n_vec; m_epc = n_epc; m_int_en = n_int_en;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 8'h00, 0, 0, 8'h10);
  endtask

  // Monitor: one expected vector per clock, sampled mid-cycle.
  logic [W-1:0] got, want;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got = {vec_sel, vec_addr, pc_stall, pc_branch_taken, pc_branch_target,
             flush_if, flush_id, irq_ack, epc, int_en};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL outputs t=%0t actual %h required %h", $time, got, want);
      end
      checks++;
      if ((pc_stall && pc_branch_taken) || (!pc_branch_taken && pc_branch_target != 8'h00)) begin
        errors++;
        $display("FAIL redirect_excl t=%0t actual stall=%b taken=%b target=%h required exclusive/zero",
                 $time, pc_stall, pc_branch_taken, pc_branch_target);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 8'(i);
    imem[RV] = 8'h20;
    imem[IV] = 8'hE0;
    m_boot = 0; m_entry = 0; m_vec = 0; m_epc = 0; m_int_en = 0;

    // Reset and boot to 0x20
    cycle(1, 0, 0, 8'h00, 0, 0, 8'h00);
    cycle(1, 0, 0, 8'h00, 0, 1, 8'h00);
    idle(4);
    // Branch beats stall
    cycle(0, 1, 1, 8'h40, 0, 0, 8'h22);
    cycle(0, 1, 0, 8'h00, 0, 0, 8'h40);
    // Interrupt entry from 0x35, handler, return
    cycle(0, 0, 0, 8'h00, 0, 1, 8'h35);
    cycle(0, 0, 0, 8'h00, 0, 1, 8'h36);
    cycle(0, 0, 0, 8'h00, 0, 1, 8'h36);
    cycle(0, 0, 0, 8'h00, 0, 1, 8'hE0);
    cycle(0, 0, 0, 8'h00, 1, 1, 8'hE1);
    cycle(0, 0, 0, 8'h00, 0, 0, 8'h35);
    // Branch while reading the vector
    cycle(0, 0, 0, 8'h00, 0, 1, 8'h37);
    cycle(0, 0, 1, 8'h50, 0, 0, 8'h38);
    cycle(0, 0, 0, 8'h00, 0, 0, 8'h38);
    idle(2);
    cycle(0, 0, 1, 8'h00, 1, 0, 8'hE2);
    // Deferred by hazard for two cycles
    cycle(0, 1, 0, 8'h00, 0, 1, 8'h60);
    cycle(0, 1, 0, 8'h00, 0, 1, 8'h60);
    cycle(0, 0, 0, 8'h00, 0, 1, 8'h60);
    cycle(0, 0, 0, 8'h00, 0, 1, 8'h61);
    cycle(0, 0, 0, 8'h00, 0, 1, 8'h61);
    // Masked: int_en is 0 in handler
    cycle(0, 0, 0, 8'h00, 0, 1, 8'hE0);
    cycle(0, 0, 0, 8'h00, 0, 1, 8'hE1);
    // Vector 0xFF and reset during INT_LD
    imem[IV] = 8'hFF;
    cycle(0, 0, 0, 8'h00, 1, 0, 8'hE2);
    cycle(0, 0, 0, 8'h00, 0, 1, 8'h70);
    cycle(0, 0, 0, 8'h00, 0, 0, 8'h71);
    cycle(1, 0, 0, 8'h00, 0, 1, 8'h71);
    cycle(0, 0, 0, 8'h00, 0, 1, 8'h00);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) imem[RV] = 8'($urandom);
      if ($urandom_range(0, 99) < 3) imem[IV] = 8'($urandom);
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 15, 8'($urandom),
            $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 30, 8'($urandom));
    end

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual %0d pending required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
